// File: rtl/gpio_pkg.sv
// gpio_bank shared constants: register map and address width.
// Optional input debounce is selected with GPIO_DEBOUNCE_EN.
package gpio_pkg;

  localparam int GPIO_ADDR_W = 3;

  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_DATA    = 3'd0;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_DIR     = 3'd1;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_IN      = 3'd2;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_RISE_EN = 3'd3;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_FALL_EN = 3'd4;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_PEND    = 3'd5;

endpackage

// File: rtl/gpio_pin_in.sv
// Per-pin input path: synchroniser, optional debounce, edge detect.
// Debounce filter is built only when GPIO_DEBOUNCE_EN is defined.
module gpio_pin_in #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pad_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_n;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
    end
  end

  assign sync_n = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  // Accept sN only after it has differed from filt long enough.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_n != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_n;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;
`else
  assign filt_o = sync_n;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= filt_o;
    end
  end

  assign rise_o = filt_o & ~prev_q;
  assign fall_o = ~filt_o & prev_q;

endmodule

// File: rtl/gpio_bank.sv
// GPIO bank: register file, read mux, edge-interrupt pending bits.
// Define GPIO_DEBOUNCE_EN to add per-pin input debounce.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int NPINS           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [GPIO_ADDR_W-1:0] addr,
  input  logic [NPINS-1:0]       wdata,
  output logic [NPINS-1:0]       rdata,
  input  logic [NPINS-1:0]       pad_in,
  output logic [NPINS-1:0]       pad_out,
  output logic [NPINS-1:0]       pad_oe,
  output logic                   irq
);

  logic [NPINS-1:0] data_q, data_d;
  logic [NPINS-1:0] dir_q, dir_d;
  logic [NPINS-1:0] ren_q, ren_d;
  logic [NPINS-1:0] fen_q, fen_d;
  logic [NPINS-1:0] pend_q, pend_d;
  logic [NPINS-1:0] rdata_q, rdata_d;
  logic [NPINS-1:0] in_filt, rise, fall;
  logic [NPINS-1:0] pend_clr, rd_mux;

  for (genvar i = 0; i < NPINS; i++) begin : g_pin
    gpio_pin_in #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_pin (
      .clk   (clk),
      .reset (reset),
      .pad_i (pad_in[i]),
      .filt_o(in_filt[i]),
      .rise_o(rise[i]),
      .fall_o(fall[i])
    );
  end

  always_comb begin
    rd_mux = '0;
    unique case (addr)
      GPIO_ADDR_DATA:    rd_mux = data_q;
      GPIO_ADDR_DIR:     rd_mux = dir_q;
      GPIO_ADDR_IN:      rd_mux = in_filt;
      GPIO_ADDR_RISE_EN: rd_mux = ren_q;
      GPIO_ADDR_FALL_EN: rd_mux = fen_q;
      GPIO_ADDR_PEND:    rd_mux = pend_q;
      default:           rd_mux = '0;
    endcase
  end

  always_comb begin
    data_d   = data_q;
    dir_d    = dir_q;
    ren_d    = ren_q;
    fen_d    = fen_q;
    pend_clr = '0;
    if (wr_en) begin
      unique case (addr)
        GPIO_ADDR_DATA:    data_d   = wdata;
        GPIO_ADDR_DIR:     dir_d    = wdata;
        GPIO_ADDR_RISE_EN: ren_d    = wdata;
        GPIO_ADDR_FALL_EN: fen_d    = wdata;
        GPIO_ADDR_PEND:    pend_clr = wdata;
        default: ;
      endcase
    end
    // A fresh edge beats a simultaneous write-1-to-clear.
    pend_d  = (pend_q & ~pend_clr)
            | (rise & ren_q)
            | (fall & fen_q);
    rdata_d = rd_en ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      dir_q   <= '0;
      ren_q   <= '0;
      fen_q   <= '0;
      pend_q  <= '0;
      rdata_q <= '0;
    end else begin
      data_q  <= data_d;
      dir_q   <= dir_d;
      ren_q   <= ren_d;
      fen_q   <= fen_d;
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata   = rdata_q;
  assign pad_out = data_q;
  assign pad_oe  = dir_q;
  assign irq     = |pend_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_gpio_bank;

  localparam int N  = 16;
  localparam int S  = 2;
  localparam int DB = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int DX = DB;
`else
  localparam int DX = 0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [2:0]   addr = '0;
  logic [N-1:0] wdata = '0;
  logic [N-1:0] pad_in = '0;
  logic [N-1:0] rdata, pad_out, pad_oe;
  logic         irq;

  int checks = 0;
  int failures = 0;

  logic [N-1:0] m_data = '0, m_dir = '0, m_re = '0, m_fe = '0;
  logic [N-1:0] m_pend = '0, m_rdata = '0, m_in = '0, m_prev = '0;
  logic [N-1:0] m_hist [S];

  gpio_bank #(
    .NPINS(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .pad_in(pad_in),
    .pad_out(pad_out), .pad_oe(pad_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return m_data;
      3'd1: return m_dir;
      3'd2: return m_in;
      3'd3: return m_re;
      3'd4: return m_fe;
      3'd5: return m_pend;
      default: return '0;
    endcase
  endfunction

  // Filtered input = pad value sampled S-1 edges earlier; edges
  // are changes of that filtered value between consecutive cycles.
  task automatic model_edge();
    logic [N-1:0] rise, fall, clr, rv;
    rise = m_in & ~m_prev;
    fall = ~m_in & m_prev;
    clr  = (wr_en && addr == 3'd5) ? wdata : '0;
    rv   = m_read(addr);
    if (reset) begin
      m_data = '0; m_dir = '0; m_re = '0; m_fe = '0;
      m_pend = '0; m_rdata = '0; m_in = '0; m_prev = '0;
      for (int i = 0; i < S; i++) m_hist[i] = '0;
    end else begin
      if (rd_en) m_rdata = rv;
      m_pend = (m_pend & ~clr) | (rise & m_re) | (fall & m_fe);
      if (wr_en) begin
        case (addr)
          3'd0: m_data = wdata;
          3'd1: m_dir  = wdata;
          3'd3: m_re   = wdata;
          3'd4: m_fe   = wdata;
          default: ;
        endcase
      end
      m_prev = m_in;
      for (int i = S - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = pad_in;
      m_in = m_hist[S-1];
    end
  endtask

  task automatic step(input logic r, input logic w, input logic rd,
                      input logic [2:0] a, input logic [N-1:0] d,
                      input logic [N-1:0] p);
    reset = r; wr_en = w; rd_en = rd; addr = a; wdata = d; pad_in = p;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [N-1:0] d);
    step(1'b0, 1'b1, 1'b0, a, d, pad_in);
  endtask

  task automatic rd(input logic [2:0] a);
    step(1'b0, 1'b0, 1'b1, a, '0, pad_in);
  endtask

  task automatic idle(input int n, input logic [N-1:0] p);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, '0, p);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 3'd0, '0, 16'hFFFF);
    step(1'b1, 1'b0, 1'b0, 3'd0, '0, 16'hFFFF);
    checks++;
    if (pad_oe !== 16'h0) begin
      failures++; $display("FAIL reset_oe got=%h exp=0000", pad_oe);
    end
    checks++;
    if (pad_out !== 16'h0) begin
      failures++; $display("FAIL reset_out got=%h exp=0000", pad_out);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL reset_irq got=%b exp=0", irq);
    end
    checks++;
    if (rdata !== 16'h0) begin
      failures++; $display("FAIL reset_rdata got=%h exp=0000", rdata);
    end
    idle(S + DX, 16'hFFFF);
    rd(3'd5);
    checks++;
    if (rdata !== 16'h0) begin
      failures++; $display("FAIL reset_pend got=%h exp=0000", rdata);
    end
    rd(3'd2);
    checks++;
    if (rdata !== 16'hFFFF) begin
      failures++; $display("FAIL reset_in got=%h exp=ffff", rdata);
    end
  endtask

  task automatic test_regs();
    wr(3'd1, 16'h00FF);
    checks++;
    if (pad_oe !== 16'h00FF) begin
      failures++; $display("FAIL dir_oe got=%h exp=00ff", pad_oe);
    end
    wr(3'd0, 16'hA5A5);
    checks++;
    if (pad_out !== 16'hA5A5) begin
      failures++; $display("FAIL data_out got=%h exp=a5a5", pad_out);
    end
    rd(3'd0);
    checks++;
    if (rdata !== 16'hA5A5) begin
      failures++; $display("FAIL data_rd got=%h exp=a5a5", rdata);
    end
    step(1'b0, 1'b1, 1'b1, 3'd0, 16'h1234, pad_in);
    checks++;
    if (rdata !== 16'hA5A5) begin
      failures++; $display("FAIL rw_same got=%h exp=a5a5", rdata);
    end
    checks++;
    if (pad_out !== 16'h1234) begin
      failures++; $display("FAIL rw_out got=%h exp=1234", pad_out);
    end
    wr(3'd2, 16'h0000);
    rd(3'd2);
    checks++;
    if (rdata !== 16'hFFFF) begin
      failures++; $display("FAIL in_ro got=%h exp=ffff", rdata);
    end
    rd(3'd7);
    checks++;
    if (rdata !== 16'h0) begin
      failures++; $display("FAIL addr7 got=%h exp=0000", rdata);
    end
  endtask

`ifndef GPIO_DEBOUNCE_EN
  task automatic test_rise_irq();
    idle(S + 2, 16'h0000);
    wr(3'd3, 16'h0001);
    wr(3'd5, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 3'd0, '0, 16'h0001);
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL rise_k got=%b exp=0", irq);
    end
    idle(1, 16'h0001);
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL rise_k1 got=%b exp=0", irq);
    end
    idle(1, 16'h0001);
    checks++;
    if (irq !== 1'b1) begin
      failures++; $display("FAIL rise_k2 got=%b exp=1", irq);
    end
    rd(3'd5);
    checks++;
    if (rdata !== 16'h0001) begin
      failures++; $display("FAIL rise_pend got=%h exp=0001", rdata);
    end
    wr(3'd5, 16'h0001);
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL rise_clr got=%b exp=0", irq);
    end
  endtask

  task automatic test_clear_race();
    wr(3'd3, 16'h0000);
    wr(3'd4, 16'h0008);
    idle(S + 2, 16'h0008);
    wr(3'd5, 16'hFFFF);
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL race_pre got=%b exp=0", irq);
    end
    step(1'b0, 1'b0, 1'b0, 3'd0, '0, 16'h0000);
    idle(1, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 3'd5, 16'h0008, 16'h0000);
    checks++;
    if (irq !== 1'b1) begin
      failures++; $display("FAIL race_irq got=%b exp=1", irq);
    end
    rd(3'd5);
    checks++;
    if (rdata !== 16'h0008) begin
      failures++; $display("FAIL race_pend got=%h exp=0008", rdata);
    end
    wr(3'd5, 16'h0008);
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL race_clr got=%b exp=0", irq);
    end
    wr(3'd4, 16'h0000);
  endtask

  task automatic test_random();
    logic [N-1:0] p;
    logic [2:0]   a;
    logic         w, r, rs;
    wr(3'd3, N'($urandom));
    wr(3'd4, N'($urandom));
    p = pad_in;
    for (int c = 0; c < 400; c++) begin
      w  = ($urandom_range(0, 3) == 0);
      r  = $urandom_range(0, 1) == 1;
      a  = (w && $urandom_range(0, 1) == 1) ? 3'd5 : 3'($urandom);
      rs = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 2) == 0) p = p ^ (N'($urandom) & N'($urandom));
      step(rs, w, r, a, N'($urandom), p);
      checks++;
      if (rdata !== m_rdata) begin
        failures++;
        $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, rdata, m_rdata);
      end
      checks++;
      if (pad_out !== m_data || pad_oe !== m_dir) begin
        failures++;
        $display("FAIL rnd_pads c=%0d got=%h/%h exp=%h/%h",
                 c, pad_out, pad_oe, m_data, m_dir);
      end
      checks++;
      if (irq !== (|m_pend)) begin
        failures++;
        $display("FAIL rnd_irq c=%0d got=%b exp=%b", c, irq, |m_pend);
      end
      if (rs) begin
        wr(3'd3, N'($urandom));
        wr(3'd4, N'($urandom));
      end
    end
  endtask
`else
  task automatic test_debounce();
    wr(3'd3, 16'hFFFF);
    idle(S + DB + 2, 16'h0000);
    wr(3'd5, 16'hFFFF);
    idle(3, 16'h0020);
    idle(12, 16'h0000);
    rd(3'd5);
    checks++;
    if (rdata !== 16'h0) begin
      failures++; $display("FAIL db_glitch got=%h exp=0000", rdata);
    end
    idle(6, 16'h0020);
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL db_early got=%b exp=0", irq);
    end
    idle(1, 16'h0000);
    checks++;
    if (irq !== 1'b1) begin
      failures++; $display("FAIL db_irq got=%b exp=1", irq);
    end
    rd(3'd5);
    checks++;
    if (rdata !== 16'h0020) begin
      failures++; $display("FAIL db_pend got=%h exp=0020", rdata);
    end
    wr(3'd3, 16'h0000);
    idle(S + DB + 2, 16'h0000);
    wr(3'd5, 16'hFFFF);
  endtask
`endif

  task automatic test_reset_mid();
    wr(3'd4, 16'h0000);
    wr(3'd3, 16'h00F0);
    idle(S + DX + 2, 16'h0000);
    wr(3'd5, 16'hFFFF);
    idle(1, 16'h00F0);
    idle(S + DX, 16'h00F0);
    rd(3'd5);
    checks++;
    if (rdata !== 16'h00F0) begin
      failures++; $display("FAIL mid_pend got=%h exp=00f0", rdata);
    end
    checks++;
    if (irq !== 1'b1) begin
      failures++; $display("FAIL mid_irq got=%b exp=1", irq);
    end
    idle(1, 16'h01F0);
    step(1'b1, 1'b0, 1'b0, 3'd0, '0, 16'h01F0);
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL mid_rst_irq got=%b exp=0", irq);
    end
    idle(S + DX + 6, 16'h01F0);
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL mid_stale got=%b exp=0", irq);
    end
    rd(3'd5);
    checks++;
    if (rdata !== 16'h0) begin
      failures++; $display("FAIL mid_pend0 got=%h exp=0000", rdata);
    end
    rd(3'd2);
    checks++;
    if (rdata !== 16'h01F0) begin
      failures++; $display("FAIL mid_in got=%h exp=01f0", rdata);
    end
  endtask

  initial begin
    test_reset();
    test_regs();
`ifndef GPIO_DEBOUNCE_EN
    test_rise_irq();
    test_clear_race();
`else
    test_debounce();
`endif
    test_reset_mid();
`ifndef GPIO_DEBOUNCE_EN
    test_random();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
